ps2_kbd_fifo: RTL and testbench

PS2_KBD_FIFO -- requirements
Module: ps2_kbd_fifo

---
 rtl/ps2_kbd_fifo.sv | 122 ++++++++++++
 tb/tb_ps2_kbd_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_fifo.sv
// rtl/ps2_kbd_fifo.sv - PS/2 keyboard receiver with scan-code FIFO and sticky overflow.
// Optional parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_kbd_fifo #(
  parameter int          FIFO_AW = 3,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rdn,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  localparam int              DEPTH   = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [2:0]        clk_sync, dat_sync;
  logic [3:0]        bit_cnt;
  logic [9:0]        shreg;
  logic [15:0]       to_cnt;
  logic              rdn_prev;
  logic [FIFO_AW:0]  wp, rp;
  logic [7:0]        mem [0:DEPTH-1];

  logic ps2_fall, ps2_bit, timed_out, frame_ok;
  logic fifo_empty, fifo_full, rd_edge, do_pop, do_push, drop;

  assign ps2_fall  = clk_sync[2] & ~clk_sync[1];
  assign ps2_bit   = dat_sync[1];
  assign timed_out = (state == SHIFT) && !ps2_fall && (to_cnt == TIMEOUT - 16'd1);

  // shreg after ten shifts: [7:0] data, [8] parity, [9] stop.
`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = shreg[9] & (^shreg[8:0]);
`else
  assign frame_ok = shreg[9];
`endif

  assign fifo_empty = (wp == rp);
  assign fifo_full  = (wp[FIFO_AW] != rp[FIFO_AW]) &&
                      (wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0]);
  assign rd_edge    = rdn_prev & ~rdn;
  assign do_pop     = rd_edge & ~fifo_empty;
  // A coincident pop frees the slot, so the push is allowed even when full.
  assign do_push    = (state == CHECK) && frame_ok && (!fifo_full || do_pop);
  assign drop       = (state == CHECK) && frame_ok && fifo_full && !do_pop;

  assign ready = ~fifo_empty;
  assign data  = mem[rp[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ps2_fall && !ps2_bit) state_nxt = SHIFT;
      SHIFT: begin
        if (timed_out)                            state_nxt = IDLE;
        else if (ps2_fall && bit_cnt == 4'd10)    state_nxt = CHECK;
      end
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      clk_sync <= 3'b111;
      dat_sync <= 3'b111;
      rdn_prev <= 1'b1;
      bit_cnt  <= 4'd0;
      to_cnt   <= 16'd0;
      shreg    <= 10'd0;
      wp       <= '0;
      rp       <= '0;
      overflow <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[1:0], ps2_data};
      rdn_prev <= rdn;
      case (state)
        IDLE: begin
          to_cnt <= 16'd0;
          if (ps2_fall && !ps2_bit) bit_cnt <= 4'd1;
        end
        SHIFT: begin
          if (ps2_fall) begin
            shreg   <= {ps2_bit, shreg[9:1]};
            bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
            to_cnt  <= 16'd0;
          end else if (timed_out) begin
            bit_cnt <= 4'd0;
            to_cnt  <= 16'd0;
          end else begin
            to_cnt  <= to_cnt + 16'd1;
          end
        end
        default: begin
          bit_cnt <= 4'd0;
          to_cnt  <= 16'd0;
        end
      endcase
      if (do_push) wp <= wp + PTR_ONE;
      if (do_pop)  rp <= rp + PTR_ONE;
      if (drop)    overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[FIFO_AW-1:0]] <= shreg[7:0];
  end

endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// tb/tb_ps2_kbd_fifo.sv - scoreboard bench for ps2_kbd_fifo.
module tb_ps2_kbd_fifo;

  localparam int          AW    = 3;
  localparam int          DEPTH = 8;
  localparam logic [15:0] TO    = 16'd100;
  localparam int          HALF  = 20;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rdn = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovf = 1'b0;

  always #5 clk = ~clk;

  ps2_kbd_fifo #(.FIFO_AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rdn(rdn), .data(data), .ready(ready), .overflow(overflow)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    clrn = 1'b0; rdn = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    tick(3);
    clrn = 1'b1;
    tick(2);
    exp_q.delete();
    exp_ovf = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  // rd_at_stop drops rdn so the read edge lands in the CHECK cycle of this frame.
  task automatic send_frame(input logic [7:0] d, input logic par_ok, input logic rd_at_stop);
    logic par;
    logic valid;
    par = par_ok ? ~^d : ^d;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    ps2_data = 1'b1;
    tick(HALF);
    ps2_clk = 1'b0;
    if (rd_at_stop) begin
      tick(3);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL coincident_head: model queue empty, ready=%0b", ready);
      end else begin
        if (data !== exp_q[0]) begin
          errors++;
          $display("FAIL coincident_head: got %02h expected %02h", data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      rdn = 1'b0;
      tick(HALF - 3);
    end else begin
      tick(HALF);
    end
    ps2_clk = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
    valid = par_ok;
`else
    valid = 1'b1;
`endif
    if (valid) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else exp_ovf = 1'b1;
    end
    tick(10);
    rdn = 1'b1;
    tick(2);
  endtask

  task automatic read_one(input string name);
    logic [7:0] e;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: got %0b expected 1", name, ready);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_data: model queue empty, got %02h", name, data);
    end else begin
      e = exp_q.pop_front();
      if (data !== e) begin
        errors++;
        $display("FAIL %s_data: got %02h expected %02h", name, data, e);
      end
    end
    rdn = 1'b0;
    tick(2);
    rdn = 1'b1;
    tick(2);
  endtask

  task automatic check_ready(input string name);
    logic e;
    e = (exp_q.size() != 0);
    checks++;
    if (ready !== e) begin
      errors++;
      $display("FAIL %s_ready: got %0b expected %0b", name, ready, e);
    end
  endtask

  task automatic check_ovf(input string name);
    checks++;
    if (overflow !== exp_ovf) begin
      errors++;
      $display("FAIL %s_overflow: got %0b expected %0b", name, overflow, exp_ovf);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_ready("reset");
    check_ovf("reset");
  endtask

  task automatic test_basic();
    send_frame(8'h1C, 1'b1, 1'b0);
    check_ready("basic");
    read_one("basic");
    check_ready("basic_after_read");
  endtask

  task automatic test_parity();
    send_frame(8'h1C, 1'b0, 1'b0);
    check_ready("parity");
    if (exp_q.size() != 0) read_one("parity");
    check_ready("parity_after");
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b0);
    check_ready("ovf_full");
    check_ovf("ovf_full");
    for (int i = 0; i < 8; i++) read_one("ovf_drain");
    check_ready("ovf_empty");
    check_ovf("ovf_sticky");
  endtask

  task automatic test_timeout();
    do_reset();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    ps2_data = 1'b1;
    tick(int'(TO) + 10);
    send_frame(8'hF0, 1'b1, 1'b0);
    read_one("timeout");
    check_ready("timeout_single");
  endtask

  task automatic test_hold_rdn();
    send_frame(8'h21, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    send_frame(8'h23, 1'b1, 1'b0);
    rdn = 1'b0;
    tick(20);
    rdn = 1'b1;
    tick(2);
    void'(exp_q.pop_front());
    read_one("hold");
    read_one("hold");
    check_ready("hold_empty");
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0);
    check_ovf("b2b_full");
    send_frame(8'hAA, 1'b1, 1'b1);
    check_ovf("b2b_coincident");
    for (int i = 0; i < 8; i++) read_one("b2b_drain");
    check_ready("b2b_empty");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_overflow();
    test_timeout();
    test_hold_rdn();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
